// File: rtl/ts_packet_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ts_packet_arbiter_pkg: shared TS constants, FSM states and helpers. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ts_packet_arbiter_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         NUM_STREAMS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {14'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ts_packet_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker: first requester at or after ptr, wrapping mod 4. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_priority_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant_idx,
  output logic       any_req
);

  logic [1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_idx = ptr;
    w_idx     = ptr;
    any_req   = |req;
    for (int k = 3; k >= 0; k--) begin
      w_idx = ptr + 2'(k);
      if (req[w_idx]) grant_idx = w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ts_packet_arbiter.sv
// ---------------------------------------------------------------------------
// ts_packet_arbiter: packet-granular round-robin merge of 4 MPEG2-TS streams.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ts_packet_arbiter
  import ts_packet_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PKT_LEN       = TS_PKT_LEN,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic [3:0]              in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [1:0]              out_src,
  output logic                    out_abort,
  output logic [15:0]             drop_cnt,
  output logic [7:0]              abort_cnt
);

  localparam int                    STALL_W    = $clog2(STALL_TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] SYNC       = DATA_WIDTH'(TS_SYNC_BYTE);
  localparam logic [7:0]            LAST_IDX   = 8'(PKT_LEN - 1);
  localparam logic [STALL_W-1:0]    STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

  state_t              r_state;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          r_grant;
  logic [7:0]          r_byte_cnt;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [15:0]         r_drop_cnt;
  logic [7:0]          r_abort_cnt;

  logic [DATA_WIDTH-1:0] w_head [NUM_STREAMS];
  logic [3:0]            w_is_sync;
  logic [3:0]            w_req;
  logic [3:0]            w_drop;
  logic [1:0]            w_pick;
  logic                  w_any_req;
  logic                  w_gvalid;
  logic                  w_xfer;

  generate
    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_head
      assign w_head[i]    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign w_is_sync[i] = (w_head[i] == SYNC);
    end
  endgenerate

  assign w_req    = in_valid & w_is_sync;
  assign w_drop   = in_valid & ~w_is_sync;
  assign w_gvalid = in_valid[r_grant];
  assign w_xfer   = (r_state == ST_PASS) && w_gvalid && out_ready;

  rr_priority_picker u_picker (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .grant_idx (w_pick),
    .any_req   (w_any_req)
  );

  // Handshake and datapath are combinational; gated off while rstn is low.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    if (rstn) begin
      unique case (r_state)
        ST_IDLE: in_ready = w_drop;
        ST_PASS: begin
          out_valid         = w_gvalid;
          out_data          = w_head[r_grant];
          in_ready[r_grant] = out_ready;
          out_sop           = w_gvalid && (r_byte_cnt == 8'd0);
          out_eop           = w_gvalid && (r_byte_cnt == LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  assign out_src   = r_grant;
  assign out_abort = rstn && (r_state == ST_ABORT);
  assign drop_cnt  = r_drop_cnt;
  assign abort_cnt = r_abort_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_byte_cnt  <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_drop_cnt <= sat_add16(r_drop_cnt, popcount4(w_drop));
          if (w_any_req) begin
            r_grant <= w_pick;
            r_state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (w_xfer) begin
            r_stall_cnt <= '0;
            if (r_byte_cnt == LAST_IDX) begin
              r_byte_cnt <= '0;
              r_rr_ptr   <= r_grant + 2'd1;
              r_state    <= ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end else if (!w_gvalid) begin
            // Backpressure with data present does not count as a stall.
            if (r_stall_cnt == STALL_LAST) r_state <= ST_ABORT;
            else                           r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          end
        end
        ST_ABORT: begin
          r_abort_cnt <= (r_abort_cnt == 8'hFF) ? r_abort_cnt : r_abort_cnt + 8'd1;
          r_rr_ptr    <= r_grant + 2'd1;
          r_byte_cnt  <= '0;
          r_stall_cnt <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ts_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ts_packet_arbiter: queue-sourced streams, per-cycle model compare. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ts_packet_arbiter;

  localparam int DW = 8;
  localparam int PL = 188;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_sop, out_eop, out_abort;
  logic [1:0]    out_src;
  logic [15:0]   drop_cnt;
  logic [7:0]    abort_cnt;

  always #5 clk = ~clk;

  ts_packet_arbiter #(.DATA_WIDTH(DW), .PKT_LEN(PL), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_src(out_src), .out_abort(out_abort),
    .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench-owned sources: each stream presents the front of its queue.
  logic [7:0] src_q [4][$];
  logic [3:0] take;
  bit         bp_mode = 0;

  // Model of the arbiter in packet terms: who owns the channel, how far along.
  int  m_owner, m_next, m_last_src, m_sent, m_quiet, m_drops, m_aborts;
  bit  m_aborting, rst_seen;
  logic [3:0] e_ready, req;
  logic       e_valid, e_sop, e_eop, e_abort, do_cmp;
  logic [7:0] e_data;
  logic [1:0] e_src;

  // Observations used by the hand-computed checks.
  int cyc = 0, obs_xfers = 0, obs_pkts = 0, obs_aborts = 0, last_xfer_cyc = 0, abort_gap = 0;
  int obs_src[$], sop_cyc[$], eop_cyc[$];

  task automatic model_reset();
    m_owner = -1; m_next = 0; m_last_src = 0; m_sent = 0; m_quiet = 0;
    m_drops = 0; m_aborts = 0; m_aborting = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    e_ready = '0; e_valid = 0; e_data = '0; e_sop = 0; e_eop = 0; e_abort = 0;
    e_src = 2'(m_last_src);
    req = '0;
    take = '0;
    do_cmp = 1'b1;
    if (!rstn) begin
      do_cmp = rst_seen;
    end else if (m_aborting) begin
      e_abort = 1;
    end else if (m_owner < 0) begin
      for (int i = 0; i < 4; i++)
        if (in_valid[i]) begin
          if (in_data[i*8 +: 8] == 8'h47) req[i] = 1'b1;
          else                            e_ready[i] = 1'b1;
        end
    end else begin
      e_valid          = in_valid[m_owner];
      e_data           = in_data[m_owner*8 +: 8];
      e_ready[m_owner] = out_ready;
      e_sop            = e_valid && (m_sent == 0);
      e_eop            = e_valid && (m_sent == PL - 1);
    end

    if (do_cmp) begin
      chk("in_ready",  32'(in_ready),  32'(e_ready));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_data",  32'(out_data),  32'(e_data));
      chk("out_sop",   32'(out_sop),   32'(e_sop));
      chk("out_eop",   32'(out_eop),   32'(e_eop));
      chk("out_src",   32'(out_src),   32'(e_src));
      chk("out_abort", 32'(out_abort), 32'(e_abort));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drops));
      chk("abort_cnt", 32'(abort_cnt), 32'(m_aborts));
    end

    if (rstn) begin
      if (out_valid && out_ready) begin
        obs_xfers++;
        last_xfer_cyc = cyc;
        if (out_sop) sop_cyc.push_back(cyc);
        if (out_eop) begin eop_cyc.push_back(cyc); obs_src.push_back(int'(out_src)); obs_pkts++; end
      end
      if (out_abort) begin obs_aborts++; abort_gap = cyc - last_xfer_cyc; end
    end

    // Advance the model to what must hold after the coming edge.
    if (!rstn) begin
      model_reset();
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      take = e_ready & in_valid;
      if (m_aborting) begin
        m_aborts   = (m_aborts < 255) ? m_aborts + 1 : 255;
        m_aborting = 0;
      end else if (m_owner < 0) begin
        int pick;
        m_drops = m_drops + $countones(take);
        if (m_drops > 65535) m_drops = 65535;
        pick = -1;
        for (int k = 0; k < 4; k++)
          if (pick < 0 && req[(m_next + k) % 4]) pick = (m_next + k) % 4;
        if (pick >= 0) begin
          m_owner = pick; m_last_src = pick; m_sent = 0; m_quiet = 0;
        end
      end else if (e_valid && out_ready) begin
        m_sent++;
        m_quiet = 0;
        if (m_sent == PL) begin m_next = (m_owner + 1) % 4; m_owner = -1; end
      end else if (!in_valid[m_owner]) begin
        m_quiet++;
        if (m_quiet == TO) begin m_aborting = 1; m_next = (m_owner + 1) % 4; m_owner = -1; end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]      = (src_q[i].size() > 0);
      in_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    out_ready = bp_mode ? ~out_ready : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (take[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    #1 drive();
  endtask

  task automatic push_pkt(input int s, input int nbytes);
    for (int k = 0; k < nbytes; k++)
      src_q[s].push_back(k == 0 ? 8'h47 : 8'(s * 37 + k * 5 + 3));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
             src_q[3].size() == 0 && m_owner < 0 && !m_aborting)) begin
      tick();
      n++;
      if (n >= budget) begin
        chk("wait_idle_timeout", 32'(n), 32'(budget + 1));
        return;
      end
    end
    tick(); tick();
  endtask

  task automatic clear_obs();
    obs_xfers = 0; obs_pkts = 0; obs_aborts = 0;
    obs_src.delete(); sop_cyc.delete(); eop_cyc.delete();
  endtask

  initial begin
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int n;
    rstn = 1'b0; out_ready = 1'b1; in_valid = '0; in_data = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rstn = 1'b1;
    tick();

    // All four sync at once, twice: order 0..3 with one idle cycle between packets.
    clear_obs();
    for (int s = 0; s < 4; s++) push_pkt(s, PL);
    drive();
    wait_idle(2000);
    for (int s = 0; s < 4; s++) push_pkt(s, PL);
    drive();
    wait_idle(2000);
    chk("rr_pkts", 32'(obs_pkts), 32'd8);
    for (int j = 0; j < 8 && j < obs_src.size(); j++) chk("rr_order", 32'(obs_src[j]), 32'(exp_order[j]));
    for (int j = 1; j < 4 && j < sop_cyc.size(); j++) chk("rr_gap", 32'(sop_cyc[j] - eop_cyc[j-1]), 32'd2);
    chk("rr_xfers", 32'(obs_xfers), 32'(8 * PL));

    // Single stream packet.
    clear_obs();
    push_pkt(0, PL); drive();
    wait_idle(500);
    chk("single_pkts", 32'(obs_pkts), 32'd1);
    chk("single_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd0);
    chk("single_xfers", 32'(obs_xfers), 32'(PL));
    chk("single_sops", 32'(sop_cyc.size()), 32'd1);
    chk("single_drop", 32'(drop_cnt), 32'd0);

    // Resync: five junk bytes ahead of a packet on stream 2.
    clear_obs();
    for (int k = 0; k < 5; k++) src_q[2].push_back(8'(k));
    push_pkt(2, PL); drive();
    wait_idle(500);
    chk("resync_drop", 32'(drop_cnt), 32'd5);
    chk("resync_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd2);
    chk("resync_xfers", 32'(obs_xfers), 32'(PL));

    // Backpressure: out_ready toggles every cycle.
    clear_obs();
    bp_mode = 1;
    push_pkt(3, PL); drive();
    wait_idle(1000);
    bp_mode = 0;
    chk("bp_xfers", 32'(obs_xfers), 32'(PL));
    chk("bp_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd3);
    chk("bp_abort", 32'(abort_cnt), 32'd0);

    // Stall: stream 1 stops after byte 50; stream 2 waits and wins next.
    clear_obs();
    push_pkt(1, 51);
    push_pkt(2, PL); drive();
    wait_idle(3000);
    chk("stall_aborts", 32'(obs_aborts), 32'd1);
    chk("stall_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("stall_gap", 32'(abort_gap), 32'(TO + 1));
    chk("stall_next_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd2);
    chk("stall_pkts", 32'(obs_pkts), 32'd1);

    // Reset in the middle of a packet on stream 2.
    clear_obs();
    push_pkt(2, PL); drive();
    n = 0;
    while (!(m_owner == 2 && m_sent >= 100) && n < 600) begin tick(); n++; end
    chk("mid_pkt_reached", 32'(m_sent), 32'd100);
    rstn = 1'b0;
    src_q[2].delete();
    push_pkt(2, PL);
    drive();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    clear_obs();
    rstn = 1'b1;
    wait_idle(500);
    chk("post_rst_pkts", 32'(obs_pkts), 32'd1);
    chk("post_rst_sops", 32'(sop_cyc.size()), 32'd1);
    chk("post_rst_xfers", 32'(obs_xfers), 32'(PL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
